// File: rtl/fwd_hazard_unit.sv
// Operand-forwarding select and load-use stall control for the IF/ID/EX/MEM/WB PE pipeline.
// Define FWD_STATS_EN to add saturating forwarding/stall statistics counters.
module fwd_hazard_unit #(
    parameter int REG_ADDR_W = 5
`ifdef FWD_STATS_EN
    ,
    parameter int STAT_W     = 32
`endif
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_reg_write,
    input  logic                  id_is_load,
    input  logic                  flush,
    output logic                  stall,
    output logic [1:0]            fwd_a_sel,
    output logic [1:0]            fwd_b_sel
`ifdef FWD_STATS_EN
    ,
    output logic [STAT_W-1:0]     stat_fwd_mem,
    output logic [STAT_W-1:0]     stat_fwd_wb,
    output logic [STAT_W-1:0]     stat_stall
`endif
);

    localparam logic [1:0] SEL_RF    = 2'b00;
    localparam logic [1:0] SEL_EXMEM = 2'b01;
    localparam logic [1:0] SEL_MEMWB = 2'b10;
    localparam logic [REG_ADDR_W-1:0] REG_X0 = {REG_ADDR_W{1'b0}};

    // Shadow tags of in-flight instructions. No WB-stage tags are held: the register
    // file writes in the first half-cycle, so nothing past MEM is ever forwarded.
    logic                  ex_v_r, ex_wr_r, ex_ld_r;
    logic [REG_ADDR_W-1:0] ex_rd_r;
    logic                  mem_v_r, mem_wr_r;
    logic [REG_ADDR_W-1:0] mem_rd_r;

    logic       ex_fwd_ok_s, ex_load_ok_s, mem_fwd_ok_s;
    logic       stall_s, enter_ex_s;
    logic [1:0] sel_a_nxt_s, sel_b_nxt_s;

    // Youngest matching producer wins; an unused operand always reads the register file.
    function automatic logic [1:0] pick_sel(input logic use_rs, input logic ex_hit,
                                            input logic mem_hit);
        logic [1:0] sel;
        if (!use_rs) begin
            sel = SEL_RF;
        end else if (ex_hit) begin
            sel = SEL_EXMEM;
        end else if (mem_hit) begin
            sel = SEL_MEMWB;
        end else begin
            sel = SEL_RF;
        end
        return sel;
    endfunction

    // Hazard detection and next operand-select computation for the ID instruction.
    always_comb begin
        ex_fwd_ok_s  = ex_v_r && ex_wr_r && !ex_ld_r && (ex_rd_r != REG_X0);
        ex_load_ok_s = ex_v_r && ex_wr_r && ex_ld_r && (ex_rd_r != REG_X0);
        mem_fwd_ok_s = mem_v_r && mem_wr_r && (mem_rd_r != REG_X0);
        stall_s      = id_valid && !flush && ex_load_ok_s &&
                       ((id_use_rs1 && (ex_rd_r == id_rs1)) ||
                        (id_use_rs2 && (ex_rd_r == id_rs2)));
        enter_ex_s   = id_valid && !stall_s && !flush;
        if (enter_ex_s) begin
            sel_a_nxt_s = pick_sel(id_use_rs1, ex_fwd_ok_s && (ex_rd_r == id_rs1),
                                   mem_fwd_ok_s && (mem_rd_r == id_rs1));
            sel_b_nxt_s = pick_sel(id_use_rs2, ex_fwd_ok_s && (ex_rd_r == id_rs2),
                                   mem_fwd_ok_s && (mem_rd_r == id_rs2));
        end else begin
            sel_a_nxt_s = SEL_RF;
            sel_b_nxt_s = SEL_RF;
        end
        stall = stall_s;
    end

    // Shadow stage registers and registered operand selects.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_v_r    <= 1'b0;
            ex_wr_r   <= 1'b0;
            ex_ld_r   <= 1'b0;
            ex_rd_r   <= REG_X0;
            mem_v_r   <= 1'b0;
            mem_wr_r  <= 1'b0;
            mem_rd_r  <= REG_X0;
            fwd_a_sel <= SEL_RF;
            fwd_b_sel <= SEL_RF;
        end else begin
            ex_v_r    <= enter_ex_s;
            ex_wr_r   <= id_reg_write;
            ex_ld_r   <= id_is_load;
            ex_rd_r   <= id_rd;
            mem_v_r   <= ex_v_r;
            mem_wr_r  <= ex_wr_r;
            mem_rd_r  <= ex_rd_r;
            fwd_a_sel <= sel_a_nxt_s;
            fwd_b_sel <= sel_b_nxt_s;
        end
    end

`ifdef FWD_STATS_EN
    logic [1:0] n_exmem_s, n_memwb_s;

    function automatic logic [STAT_W-1:0] sat_add(input logic [STAT_W-1:0] cur,
                                                  input logic [1:0] inc);
        logic [STAT_W:0] sum;
        sum = {1'b0, cur} + {{(STAT_W-1){1'b0}}, inc};
        if (sum[STAT_W]) begin
            return {STAT_W{1'b1}};
        end else begin
            return sum[STAT_W-1:0];
        end
    endfunction

    // Per-cycle increments: each operand select counts once at the edge it is registered.
    always_comb begin
        n_exmem_s = {1'b0, sel_a_nxt_s == SEL_EXMEM} + {1'b0, sel_b_nxt_s == SEL_EXMEM};
        n_memwb_s = {1'b0, sel_a_nxt_s == SEL_MEMWB} + {1'b0, sel_b_nxt_s == SEL_MEMWB};
    end

    // Saturating statistics counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_fwd_mem <= {STAT_W{1'b0}};
            stat_fwd_wb  <= {STAT_W{1'b0}};
            stat_stall   <= {STAT_W{1'b0}};
        end else begin
            stat_fwd_mem <= sat_add(stat_fwd_mem, n_exmem_s);
            stat_fwd_wb  <= sat_add(stat_fwd_wb, n_memwb_s);
            stat_stall   <= sat_add(stat_stall, {1'b0, stall_s});
        end
    end
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit: an instruction-history model checked every cycle,
// plus hand-computed expectations for each scenario.
module tb_fwd_hazard_unit;
    localparam int RW = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          id_valid = 1'b0, id_use_rs1 = 1'b0, id_use_rs2 = 1'b0;
    logic          id_reg_write = 1'b0, id_is_load = 1'b0, flush = 1'b0;
    logic [RW-1:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
    logic          stall;
    logic [1:0]    fwd_a_sel, fwd_b_sel;
`ifdef FWD_STATS_EN
    logic [31:0]   stat_fwd_mem, stat_fwd_wb, stat_stall;
`endif

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    fwd_hazard_unit dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
        .id_reg_write(id_reg_write), .id_is_load(id_is_load), .flush(flush),
        .stall(stall), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel)
`ifdef FWD_STATS_EN
        , .stat_fwd_mem(stat_fwd_mem), .stat_fwd_wb(stat_fwd_wb), .stat_stall(stat_stall)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: the instructions that entered EX, by age (0 = now in EX, 1 = now in MEM).
    logic          m_v [2];
    logic          m_wr[2];
    logic          m_ld[2];
    logic [RW-1:0] m_rd[2];
    logic [1:0]    m_a = 2'b00, m_b = 2'b00;
    logic          m_go;

    function automatic logic m_stall();
        if (!id_valid || flush || !m_v[0] || !m_wr[0] || !m_ld[0] || m_rd[0] == 0) return 1'b0;
        return (id_use_rs1 && m_rd[0] == id_rs1) || (id_use_rs2 && m_rd[0] == id_rs2);
    endfunction

    function automatic logic [1:0] m_sel(input logic use_r, input logic [RW-1:0] r);
        if (!use_r || r == 0) return 2'b00;
        for (int age = 0; age < 2; age++) begin
            if (m_v[age] && m_wr[age] && m_rd[age] == r && !(age == 0 && m_ld[age]))
                return (age == 0) ? 2'b01 : 2'b10;
        end
        return 2'b00;
    endfunction

    // Compare against the model mid-cycle, then advance it with the inputs the next edge samples.
    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            check("stall", {31'b0, stall}, {31'b0, m_stall()});
            check("fwd_a_sel", {30'b0, fwd_a_sel}, {30'b0, m_a});
            check("fwd_b_sel", {30'b0, fwd_b_sel}, {30'b0, m_b});
        end
        if (rst) begin
            m_v[0] = 1'b0; m_v[1] = 1'b0; m_a = 2'b00; m_b = 2'b00;
        end else begin
            m_go = id_valid && !flush && !m_stall();
            m_a = m_go ? m_sel(id_use_rs1, id_rs1) : 2'b00;
            m_b = m_go ? m_sel(id_use_rs2, id_rs2) : 2'b00;
            m_v[1] = m_v[0]; m_wr[1] = m_wr[0]; m_ld[1] = m_ld[0]; m_rd[1] = m_rd[0];
            m_v[0] = m_go; m_wr[0] = id_reg_write; m_ld[0] = id_is_load; m_rd[0] = id_rd;
        end
    end

    task automatic issue(input logic v, input logic [RW-1:0] rs1, input logic [RW-1:0] rs2,
                         input logic u1, input logic u2, input logic [RW-1:0] rd,
                         input logic wr, input logic ld, input logic fl);
        @(posedge clk);
        #1;
        id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2;
        id_rd = rd; id_reg_write = wr; id_is_load = ld; flush = fl;
    endtask

    task automatic alu(input logic [RW-1:0] rd, input logic [RW-1:0] rs1, input logic [RW-1:0] rs2);
        issue(1'b1, rs1, rs2, 1'b1, 1'b1, rd, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic load(input logic [RW-1:0] rd, input logic [RW-1:0] rs1);
        issue(1'b1, rs1, 5'd0, 1'b1, 1'b0, rd, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic bubble(input int n);
        for (int i = 0; i < n; i++) issue(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic at_neg();
        @(negedge clk);
        #1;
    endtask

    task automatic pin(input string name, input logic st, input logic [1:0] a, input logic [1:0] b);
        check({name, "_stall"}, {31'b0, stall}, {31'b0, st});
        check({name, "_a"}, {30'b0, fwd_a_sel}, {30'b0, a});
        check({name, "_b"}, {30'b0, fwd_b_sel}, {30'b0, b});
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk_en = 1'b1;
        at_neg(); pin("reset", 1'b0, 2'b00, 2'b00);

        // add x5; add x6,x5,x1 -> EX/MEM forward on rs1
        alu(5'd5, 5'd1, 5'd2); at_neg(); check("s1_st0", {31'b0, stall}, 32'd0);
        alu(5'd6, 5'd5, 5'd1); at_neg(); check("s1_st1", {31'b0, stall}, 32'd0);
        bubble(1); at_neg(); pin("s1", 1'b0, 2'b01, 2'b00);
        bubble(3);

        // add x5; nop; sub x7,x2,x5 -> MEM/WB forward on rs2
        alu(5'd5, 5'd1, 5'd2); bubble(1); alu(5'd7, 5'd2, 5'd5);
        bubble(1); at_neg(); pin("s2", 1'b0, 2'b00, 2'b10);
        bubble(3);

        // lw x8; add x9,x8,x8 -> one stall cycle, bubble in EX, then MEM/WB on both
        load(5'd8, 5'd1);
        alu(5'd9, 5'd8, 5'd8); at_neg(); check("s3_stall", {31'b0, stall}, 32'd1);
        alu(5'd9, 5'd8, 5'd8); at_neg(); pin("s3_retry", 1'b0, 2'b00, 2'b00);
        bubble(1); at_neg(); pin("s3_ex", 1'b0, 2'b10, 2'b10);
        bubble(3);
`ifdef FWD_STATS_EN
        at_neg();
        check("stat_fwd_mem", stat_fwd_mem, 32'd1);
        check("stat_fwd_wb", stat_fwd_wb, 32'd3);
        check("stat_stall", stat_stall, 32'd1);
`endif

        // x0 is never forwarded and never stalls
        alu(5'd0, 5'd1, 5'd2);
        alu(5'd3, 5'd0, 5'd0); at_neg(); check("x0_st", {31'b0, stall}, 32'd0);
        bubble(1); at_neg(); pin("x0", 1'b0, 2'b00, 2'b00);
        load(5'd0, 5'd1);
        alu(5'd3, 5'd0, 5'd0); at_neg(); check("x0_ld_st", {31'b0, stall}, 32'd0);
        bubble(3);

        // add x4; add x4; use x4 -> youngest producer wins
        alu(5'd4, 5'd1, 5'd2); alu(5'd4, 5'd1, 5'd2); alu(5'd10, 5'd4, 5'd4);
        bubble(1); at_neg(); pin("dbl", 1'b0, 2'b01, 2'b01);
        bubble(3);

        // lw x8 in EX with flush -> no stall, bubble enters EX
        load(5'd8, 5'd1);
        issue(1'b1, 5'd8, 5'd8, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 1'b1);
        at_neg(); check("fl_stall", {31'b0, stall}, 32'd0);
        alu(5'd11, 5'd9, 5'd8);
        bubble(1); at_neg(); pin("fl", 1'b0, 2'b00, 2'b10);
        bubble(3);

        // reset asserted during a load-use stall
        load(5'd8, 5'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        id_valid = 1'b1; id_rs1 = 5'd8; id_rs2 = 5'd8; id_use_rs1 = 1'b1; id_use_rs2 = 1'b1;
        id_rd = 5'd9; id_reg_write = 1'b1; id_is_load = 1'b0; flush = 1'b0;
        at_neg(); check("rs_stall", {31'b0, stall}, 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        at_neg(); pin("rs_after", 1'b0, 2'b00, 2'b00);
`ifdef FWD_STATS_EN
        check("stat_stall_clr", stat_stall, 32'd0);
`endif
        bubble(3);
        at_neg();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not reach the end of the stimulus");
        $fatal(1, "timeout");
    end

endmodule
